// File: rtl/cv_ctrl_pkg.sv
// Shared controller-port definitions: quadrature phase type, phase-to-pin table
// and the accumulator saturation helper.
package cv_ctrl_pkg;

    localparam int unsigned CV_CNT_W   = 16;
    localparam int unsigned CV_DELTA_W = 8;

    typedef logic [1:0] cv_quad_ph_t;

    // {A,B} pin levels per phase; neighbours differ in one bit so each step is a single edge
    localparam logic [1:0] CV_QUAD_PINS [4] = '{2'b11, 2'b01, 2'b00, 2'b10};

    // Clamp a signed value into the range of a width-bit two's complement number
    function automatic int cv_sat(input int value, input int unsigned width);
        int hi;
        int lo;
        int res;
        hi  = int'((32'd1 << (width - 32'd1)) - 32'd1);
        lo  = -hi - 1;
        res = value;
        if (value > hi) begin
            res = hi;
        end else if (value < lo) begin
            res = lo;
        end
        return res;
    endfunction

endpackage

// File: rtl/cv_quad_chan.sv
// One spinner channel: signed motion accumulator drained as rate-limited
// quadrature steps on a pin-7/pin-9 pair.
module cv_quad_chan #(
    parameter int unsigned STEP_DIV = 2140,
    parameter int unsigned ACC_W    = 10
) (
    input  logic              clk_i,
    input  logic              reset_n_i,
    input  logic              clk_en_i,
    input  logic              enable_i,
    input  logic              delta_valid_i,
    input  logic signed [7:0] delta_i,
    output logic              ctrl_p7_o,
    output logic              ctrl_p9_o,
    output logic              busy_o
);
    import cv_ctrl_pkg::*;

    localparam int unsigned          SUM_W    = ACC_W + 1;
    localparam logic [CV_CNT_W-1:0]  CNT_LAST = CV_CNT_W'(STEP_DIV - 1);

    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_d;
    logic [CV_CNT_W-1:0]     cnt;
    logic [CV_CNT_W-1:0]     cnt_d;
    cv_quad_ph_t             ph;
    cv_quad_ph_t             ph_d;

    logic                    cap;
    logic                    acc_nz;
    logic                    tick;
    logic [1:0]              dir;
    logic [SUM_W-1:0]        acc_x;
    logic [SUM_W-1:0]        delta_x;
    logic [SUM_W-1:0]        dir_x;
    logic signed [SUM_W-1:0] sum;

    // Next-state: capture and tick are both folded into one saturating update
    always_comb begin
        cap     = enable_i & delta_valid_i;
        acc_nz  = (acc != '0);
        tick    = enable_i & clk_en_i & acc_nz & (cnt == CNT_LAST);
        dir     = 2'b00;
        if (tick) begin
            dir = acc[ACC_W-1] ? 2'b11 : 2'b01;
        end

        acc_x   = {acc[ACC_W-1], acc};
        delta_x = cap ? {{(SUM_W-CV_DELTA_W){delta_i[CV_DELTA_W-1]}}, delta_i} : '0;
        dir_x   = {{(SUM_W-2){dir[1]}}, dir};
        sum     = acc_x + delta_x - dir_x;

        acc_d   = acc;
        cnt_d   = cnt;
        ph_d    = ph;
        if (!enable_i) begin
            acc_d = '0;
            cnt_d = '0;
            ph_d  = '0;
        end else begin
            acc_d = ACC_W'(cv_sat(int'(sum), ACC_W));
            if (!acc_nz || tick) begin
                cnt_d = '0;
            end else if (clk_en_i) begin
                cnt_d = cnt + 1'b1;
            end
            if (tick) begin
                ph_d = dir[1] ? ph - 2'd1 : ph + 2'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            acc <= '0;
            cnt <= '0;
            ph  <= '0;
        end else begin
            acc <= acc_d;
            cnt <= cnt_d;
            ph  <= ph_d;
        end
    end

    // Pins and busy are decoded from the state registers, one clock behind them
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            ctrl_p7_o <= 1'b1;
            ctrl_p9_o <= 1'b1;
            busy_o    <= 1'b0;
        end else begin
            ctrl_p7_o <= CV_QUAD_PINS[ph][1];
            ctrl_p9_o <= CV_QUAD_PINS[ph][0];
            busy_o    <= acc_nz;
        end
    end

endmodule

// File: rtl/cv_spinner_quad.sv
// Two-player ColecoVision roller/spinner front end: two independent quadrature
// channels driving controller pins 7 and 9.
module cv_spinner_quad #(
    parameter int unsigned STEP_DIV = 2140,
    parameter int unsigned ACC_W    = 10
) (
    input  logic        clk_i,
    input  logic        reset_n_i,
    input  logic        clk_en_i,
    input  logic [1:0]  enable_i,
    input  logic [1:0]  delta_valid_i,
    input  logic [15:0] delta_i,
    output logic [1:0]  ctrl_p7_o,
    output logic [1:0]  ctrl_p9_o,
    output logic [1:0]  busy_o
);

    for (genvar g = 0; g < 2; g++) begin : g_chan
        cv_quad_chan #(
            .STEP_DIV (STEP_DIV),
            .ACC_W    (ACC_W)
        ) u_chan (
            .clk_i         (clk_i),
            .reset_n_i     (reset_n_i),
            .clk_en_i      (clk_en_i),
            .enable_i      (enable_i[g]),
            .delta_valid_i (delta_valid_i[g]),
            .delta_i       (delta_i[8*g +: 8]),
            .ctrl_p7_o     (ctrl_p7_o[g]),
            .ctrl_p9_o     (ctrl_p9_o[g]),
            .busy_o        (busy_o[g])
        );
    end

endmodule

// File: tb/tb_cv_spinner_quad.sv
// Bench for cv_spinner_quad: directed scenarios plus randomized deltas checked
// against net quadrature displacement decoded from the pins.
module tb_cv_spinner_quad;

    localparam int STEP = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        clk_en = 1'b0;
    logic [1:0]  enable;
    logic [1:0]  dval;
    logic [15:0] delta;
    logic [1:0]  ctrl_p7;
    logic [1:0]  ctrl_p9;
    logic [1:0]  busy;

    int tests = 0;
    int fails = 0;

    // pin monitor state
    logic [1:0] mon_en;
    logic [1:0] prev [2];
    int         pos [2];
    int         nchg [2];
    int         last_en [2];
    logic [1:0] hist0 [$];
    logic [1:0] hist1 [$];
    int         gap0 [$];

    int div = 0;
    int en_total = 0;

    cv_spinner_quad #(.STEP_DIV(STEP), .ACC_W(10)) dut (
        .clk_i         (clk),
        .reset_n_i     (reset_n),
        .clk_en_i      (clk_en),
        .enable_i      (enable),
        .delta_valid_i (dval),
        .delta_i       (delta),
        .ctrl_p7_o     (ctrl_p7),
        .ctrl_p9_o     (ctrl_p9),
        .busy_o        (busy)
    );

    always #5 clk = ~clk;

    // clock enable every 4th clock, with a running count of enables seen at posedge
    always @(posedge clk) begin
        div    <= (div == 3) ? 0 : div + 1;
        clk_en <= (div == 2);
        if (clk_en) en_total <= en_total + 1;
    end

    function automatic logic [1:0] ph_of(input logic a, input logic b);
        if (a && b)        return 2'd0;
        else if (!a && b)  return 2'd1;
        else if (!a && !b) return 2'd2;
        else               return 2'd3;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    // advance to the next falling edge and decode any pin change into a +/-1 step
    task automatic cyc();
        logic [1:0] cur;
        int d;
        int gap;
        @(negedge clk);
        for (int p = 0; p < 2; p++) begin
            cur = ph_of(ctrl_p7[p], ctrl_p9[p]);
            if (!mon_en[p]) begin
                prev[p]    = cur;
                last_en[p] = en_total;
            end else if (cur != prev[p]) begin
                d   = (int'(cur) - int'(prev[p])) & 3;
                gap = en_total - last_en[p];
                tests++;
                assert (d == 1 || d == 3) else begin
                    fails++;
                    $error("FAIL phase_skip p%0d: observed %0d expected 1 or 3", p, d);
                end
                tests++;
                assert (gap >= STEP) else begin
                    fails++;
                    $error("FAIL dwell p%0d: observed %0d expected >= %0d", p, gap, STEP);
                end
                pos[p]  += (d == 1) ? 1 : ((d == 3) ? -1 : 0);
                nchg[p] += 1;
                if (p == 0) begin
                    hist0.push_back(cur);
                    gap0.push_back(gap);
                end else begin
                    hist1.push_back(cur);
                end
                prev[p]    = cur;
                last_en[p] = en_total;
            end
        end
    endtask

    task automatic send(input int p, input int d);
        dval[p] = 1'b1;
        delta[8*p +: 8] = 8'(d);
        cyc();
        dval[p] = 1'b0;
    endtask

    task automatic wait_idle(input int p, input int budget, input string tag);
        int n = 0;
        cyc();
        cyc();
        while (busy[p] !== 1'b0 && n < budget) begin
            cyc();
            n++;
        end
        chk(tag, 32'(n < budget), 32'd1);
        for (int k = 0; k < 3 * STEP * 4; k++) cyc();
    endtask

    task automatic wait_changes(input int p, input int target, input string tag);
        int n = 0;
        while (nchg[p] < target && n < 400) begin
            cyc();
            n++;
        end
        chk(tag, 32'(n < 400), 32'd1);
    endtask

    initial begin
        int base;
        int pos0;
        int pos1;
        int n;
        int cnt_en;
        int sum0;
        int sum1;
        int d0;
        int d1;
        logic [1:0] exp_seq [$];

        reset_n = 1'b0;
        enable  = 2'b00;
        dval    = 2'b00;
        delta   = '0;
        mon_en  = 2'b00;
        pos     = '{0, 0};
        nchg    = '{0, 0};
        for (int k = 0; k < 4; k++) cyc();
        chk("reset_p7", 32'(ctrl_p7), 32'd3);
        chk("reset_p9", 32'(ctrl_p9), 32'd3);
        chk("reset_busy", 32'(busy), 32'd0);
        reset_n = 1'b1;
        cyc();

        // 1: reset asserted mid-clock in the middle of a sequence
        enable = 2'b01;
        send(0, 5);
        for (int k = 0; k < 2 * STEP * 4 + 4; k++) cyc();
        chk("pre_reset_busy0", 32'(busy[0]), 32'd1);
        @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        chk("async_reset_p7", 32'(ctrl_p7), 32'd3);
        chk("async_reset_p9", 32'(ctrl_p9), 32'd3);
        chk("async_reset_busy", 32'(busy), 32'd0);
        cyc();
        cyc();
        reset_n = 1'b1;
        n = 0;
        for (int k = 0; k < 1000; k++) begin
            cyc();
            if (ctrl_p7 !== 2'b11 || ctrl_p9 !== 2'b11 || busy !== 2'b00) n++;
        end
        chk("idle_after_reset_bad_cycles", 32'(n), 32'd0);
        mon_en = 2'b11;
        cyc();

        // 2: forward +3 on player 0
        base = hist0.size();
        pos1 = nchg[1];
        dval[0] = 1'b1;
        delta[7:0] = 8'd3;
        cyc();
        dval[0] = 1'b0;
        chk("busy0_same_cycle", 32'(busy[0]), 32'd0);
        cyc();
        chk("busy0_rise", 32'(busy[0]), 32'd1);
        wait_idle(0, 300, "fwd_idle_timeout");
        chk("fwd_changes", 32'(hist0.size() - base), 32'd3);
        exp_seq = '{2'd1, 2'd2, 2'd3};
        for (int k = 0; k < 3; k++)
            if (base + k < hist0.size()) chk($sformatf("fwd_ph%0d", k), 32'(hist0[base+k]), 32'(exp_seq[k]));
        for (int k = 1; k < 3; k++)
            if (base + k < gap0.size()) chk($sformatf("fwd_gap%0d", k), 32'(gap0[base+k]), 32'(STEP));
        chk("fwd_busy0_end", 32'(busy[0]), 32'd0);
        chk("fwd_p1_untouched", 32'(nchg[1] - pos1), 32'd0);
        chk("fwd_p1_pins", 32'({ctrl_p7[1], ctrl_p9[1]}), 32'd3);

        // 3: reverse -2 with +4 injected after the first step, starting from phase 0
        mon_en[0] = 1'b0;
        enable[0] = 1'b0;
        for (int k = 0; k < 3; k++) cyc();
        chk("dis0_pins", 32'({ctrl_p7[0], ctrl_p9[0]}), 32'd3);
        mon_en[0] = 1'b1;
        enable[0] = 1'b1;
        cyc();
        base = hist0.size();
        pos0 = pos[0];
        send(0, -2);
        wait_changes(0, nchg[0] + 1, "rev_first_step_timeout");
        send(0, 4);
        wait_idle(0, 400, "rev_idle_timeout");
        chk("rev_changes", 32'(hist0.size() - base), 32'd4);
        exp_seq = '{2'd3, 2'd0, 2'd1, 2'd2};
        for (int k = 0; k < 4; k++)
            if (base + k < hist0.size()) chk($sformatf("rev_ph%0d", k), 32'(hist0[base+k]), 32'(exp_seq[k]));
        chk("rev_net", 32'(pos[0] - pos0), 32'd2);

        // 4: saturation at +511 and -512
        base = nchg[0];
        pos0 = pos[0];
        for (int k = 0; k < 8; k++) send(0, 127);
        wait_idle(0, 511 * STEP * 4 + 400, "satp_idle_timeout");
        chk("satp_steps", 32'(nchg[0] - base), 32'd511);
        chk("satp_net", 32'(pos[0] - pos0), 32'd511);
        base = nchg[0];
        pos0 = pos[0];
        for (int k = 0; k < 8; k++) send(0, -128);
        wait_idle(0, 512 * STEP * 4 + 400, "satn_idle_timeout");
        chk("satn_steps", 32'(nchg[0] - base), 32'd512);
        chk("satn_net", 32'(pos[0] - pos0), -32'sd512);

        // 5: +1 captured on the very edge that ticks acc=1
        base = nchg[0];
        pos0 = pos[0];
        send(0, 1);
        cnt_en = 0;
        n = 0;
        while (n < 100) begin
            if (clk_en) cnt_en++;
            if (cnt_en == STEP) break;
            cyc();
            n++;
        end
        chk("sim_align_timeout", 32'(n < 100), 32'd1);
        send(0, 1);
        cyc();
        chk("sim_one_step_so_far", 32'(nchg[0] - base), 32'd1);
        chk("sim_busy_kept", 32'(busy[0]), 32'd1);
        wait_idle(0, 200, "sim_idle_timeout");
        chk("sim_steps", 32'(nchg[0] - base), 32'd2);
        chk("sim_net", 32'(pos[0] - pos0), 32'd2);

        // 6: disable player 1 at phase 2 with acc=5, then re-enable with +1
        enable = 2'b11;
        cyc();
        base = nchg[1];
        send(1, 7);
        wait_changes(1, base + 2, "dis_two_steps_timeout");
        chk("dis_at_phase2", 32'(ph_of(ctrl_p7[1], ctrl_p9[1])), 32'd2);
        chk("dis_busy_before", 32'(busy[1]), 32'd1);
        mon_en[1] = 1'b0;
        enable[1] = 1'b0;
        cyc();
        cyc();
        chk("dis_pins", 32'({ctrl_p7[1], ctrl_p9[1]}), 32'd3);
        chk("dis_busy", 32'(busy[1]), 32'd0);
        send(1, 9);
        n = 0;
        for (int k = 0; k < 50; k++) begin
            cyc();
            if (busy[1] !== 1'b0 || {ctrl_p7[1], ctrl_p9[1]} !== 2'b11) n++;
        end
        chk("dis_ignored_bad_cycles", 32'(n), 32'd0);
        mon_en[1] = 1'b1;
        enable[1] = 1'b1;
        base = hist1.size();
        send(1, 1);
        wait_idle(1, 200, "reen_idle_timeout");
        chk("reen_changes", 32'(hist1.size() - base), 32'd1);
        if (base < hist1.size()) chk("reen_ph", 32'(hist1[base]), 32'd1);

        // random: small signed deltas on both players; net displacement must equal their sum
        pos0 = pos[0];
        pos1 = pos[1];
        sum0 = 0;
        sum1 = 0;
        for (int it = 0; it < 40; it++) begin
            d0 = int'($urandom_range(16)) - 8;
            d1 = int'($urandom_range(16)) - 8;
            dval = 2'(($urandom_range(3)));
            delta = {8'(d1), 8'(d0)};
            if (dval[0]) sum0 += d0;
            if (dval[1]) sum1 += d1;
            cyc();
            dval = 2'b00;
            n = int'($urandom_range(20));
            for (int k = 0; k < n; k++) cyc();
        end
        wait_idle(0, 8000, "rand_idle0_timeout");
        wait_idle(1, 8000, "rand_idle1_timeout");
        chk("rand_net0", 32'(pos[0] - pos0), 32'(sum0));
        chk("rand_net1", 32'(pos[1] - pos1), 32'(sum1));
        chk("rand_busy_end", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
